uart_bus_arbiter: RTL
=====================

// Module: uart_bus_arbiter
// PURPOSE
//   Shares the single bus_protocol_if slave port of AHBUart between NumReq requesters
//   (e.g. CPU bridge, DMA, debug). Arbitration is round-robin; the grant is locked for
//   the whole duration of a stalled transfer. An optional stall timeout completes a
//   stuck transfer with an error.
//   Sits between the requesters and the bus_protocol_if of the UART, alongside AHBUart_tl.
// PARAMETERS
//   NumReq      2   number of requesters, range 2..8
//   TimeoutCyc  0   maximum consecutive stalled cycles before abort; 0 disables the timeout
// PORTS
//   clk            in   1         single clock, all flops posedge
//   nReset         in   1         async active-low reset
//   req_wen        in   NumReq    per-requester write enable
//   req_ren        in   NumReq    per-requester read enable
//   req_addr       in   NumRx32   per-requester address
//   req_wdata      in   NumRx32   per-requester write data
//   req_strobe     in   NumRx4    per-requester byte strobe
//   req_rdata      out  NumRx32   per-requester read data
//   req_error      out  NumReq    per-requester error
//   req_stall      out  NumReq    per-requester request_stall
//   bp_wen         out  1         to the UART bus_protocol_if
//   bp_ren         out  1         to the UART bus_protocol_if
//   bp_addr        out  32        to the UART bus_protocol_if
//   bp_wdata       out  32        to the UART bus_protocol_if
//   bp_strobe      out  4         to the UART bus_protocol_if
//   bp_rdata       in   32        from the UART
//   bp_error       in   1         from the UART
//   bp_stall       in   1         request_stall from the UART
// BEHAVIOUR
//   - Requester i is active when req_wen[i] | req_ren[i].
//   - A transfer completes in the first cycle it is forwarded with bp_stall == 0.
//   - Reset state: IDLE, ptr = 0, tcnt = 0.
//     While nReset is 0: bp_wen = bp_ren = 0, req_stall = '1, req_rdata = 0, req_error = 0.
//   - State IDLE: combinational pick of the first active requester, searching from ptr
//     upward and wrapping modulo NumReq. The winner's bus fields are forwarded to bp_*
//     in the same cycle (zero added latency).
//     - bp_stall == 0: complete; ptr <= winner + 1 (wraps); stay IDLE.
//     - bp_stall == 1: owner <= winner; go to BUSY.
//   - State BUSY: forward the owner only. New requests from others are ignored until
//     completion.
//     - bp_stall == 0: complete; ptr <= owner + 1; go to IDLE.
//     - Owner drops wen/ren (protocol violation): bp_wen = bp_ren = 0 that cycle; go to
//       IDLE; ptr unchanged.
//     - TimeoutCyc > 0 and tcnt == TimeoutCyc - 1 while still stalled:
//       req_error[owner] = 1, req_stall[owner] = 0, bp_wen = bp_ren = 0 for that cycle;
//       ptr <= owner + 1; go to IDLE.
//   - tcnt: clears on entry to BUSY and in IDLE; increments each stalled BUSY cycle;
//     saturates; width $clog2(TimeoutCyc + 1).
//   - Output routing:
//     - Granted requester: req_rdata = bp_rdata, req_error = bp_error, req_stall = bp_stall.
//     - Non-granted active requesters: req_stall = 1, rdata = 0, error = 0.
//     - Inactive requesters: req_stall = 0, rdata = 0, error = 0.
//   - No request active in IDLE: bp_* all 0.
//   - wen and ren both set: forwarded unchanged; the UART owns that error.
//   - Async reset mid-BUSY: transfer abandoned; downstream enables drop immediately.
// STRUCTURE
//   - uart_arb_pkg:
//     - typedef enum logic {IDLE, BUSY} arb_state_t
//     - typedef struct {wen, ren, addr, wdata, strobe} bp_req_t
//     - localparam MaxReq = 8
//   - Sub-module rr_pick #(N): inputs active vector and ptr; outputs winner index and a
//     valid flag; purely combinational.
//   - Top level holds state, owner, ptr and tcnt flops plus the routing muxes.
// TESTING (NumReq = 2, TimeoutCyc = 8 unless stated)
//   1. Req0 reads 0x04 and req1 writes 0x00 (wdata 0x41) in the same cycle, bp_stall = 0,
//      ptr = 0 -> req0 completes in cycle 0 with req1 stall = 1; req1 completes in cycle 1.
//   2. Both requesters issue back-to-back requests for 4 cycles -> grants alternate
//      0, 1, 0, 1.
//   3. Req1 write while bp_stall = 1 for 3 cycles; req0 requests in cycle 1 -> bp_* holds
//      req1's fields; req1 completes in cycle 3; req0 is granted in cycle 4.
//   4. bp_stall held at 1 -> at the 8th stalled cycle req_error[owner] = 1 and stall = 0;
//      the following cycle is IDLE.
//   5. nReset pulsed low in BUSY -> bp_wen = bp_ren = 0 at once; after release ptr = 0
//      and req0 wins a tie.
//   6. Owner drops ren mid-stall -> bp_ren = 0 the same cycle; next cycle IDLE and ptr
//      unchanged.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART bus arbiter: FSM states, the forwarded bus request
// bundle, and the supported requester limit.
package uart_arb_pkg;
  localparam int MaxReq = 8;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef struct packed {
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
  } bp_req_t;
endpackage

// File: rtl/uart_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first active requester at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  active,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);
  logic [PW-1:0] cand;

  // Walk from the farthest distance back to ptr so the nearest active one wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % N);
      if (active[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing the UART bus_protocol_if slave between NumReq
// requesters; grant is locked across stalls with an optional stall timeout.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NumReq     = 2,
  parameter int TimeoutCyc = 0
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic [NumReq-1:0]       req_wen,
  input  logic [NumReq-1:0]       req_ren,
  input  logic [NumReq-1:0][31:0] req_addr,
  input  logic [NumReq-1:0][31:0] req_wdata,
  input  logic [NumReq-1:0][3:0]  req_strobe,
  output logic [NumReq-1:0][31:0] req_rdata,
  output logic [NumReq-1:0]       req_error,
  output logic [NumReq-1:0]       req_stall,
  output logic                    bp_wen,
  output logic                    bp_ren,
  output logic [31:0]             bp_addr,
  output logic [31:0]             bp_wdata,
  output logic [3:0]              bp_strobe,
  input  logic [31:0]             bp_rdata,
  input  logic                    bp_error,
  input  logic                    bp_stall
);
  localparam int PW = $clog2(NumReq);
  localparam int TW = (TimeoutCyc > 0) ? $clog2(TimeoutCyc + 1) : 1;
  localparam logic [TW-1:0] TLast = TW'((TimeoutCyc > 0) ? TimeoutCyc - 1 : 0);

  arb_state_t            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d, owner_q, owner_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [NumReq-1:0]     active;
  bp_req_t [NumReq-1:0]  reqs;
  bp_req_t               fwd;
  logic [PW-1:0]         win_idx, gnt_idx;
  logic                  win_vld, gnt_vld, abort;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (int'(i) == NumReq - 1) ? '0 : i + 1'b1;
  endfunction

  assign active = req_wen | req_ren;

  always_comb begin
    for (int i = 0; i < NumReq; i++)
      reqs[i] = {req_wen[i], req_ren[i], req_addr[i], req_wdata[i], req_strobe[i]};
  end

  rr_pick #(.N(NumReq)) u_pick (
    .active (active),
    .ptr    (ptr_q),
    .idx    (win_idx),
    .valid  (win_vld)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    tcnt_d  = tcnt_q;
    gnt_vld = 1'b0;
    gnt_idx = win_idx;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (win_vld) begin
          gnt_vld = 1'b1;
          if (!bp_stall) begin
            ptr_d = wrap_inc(win_idx);
          end else begin
            owner_d = win_idx;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        gnt_idx = owner_q;
        if (!active[owner_q]) begin
          // Owner walked away mid-transfer: drop the bus, keep fairness pointer.
          state_d = IDLE;
          tcnt_d  = '0;
        end else begin
          gnt_vld = 1'b1;
          if (!bp_stall) begin
            ptr_d   = wrap_inc(owner_q);
            state_d = IDLE;
          end else if (TimeoutCyc > 0 && tcnt_q == TLast) begin
            abort   = 1'b1;
            ptr_d   = wrap_inc(owner_q);
            state_d = IDLE;
          end else if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fwd       = gnt_vld ? reqs[gnt_idx] : '0;
    bp_wen    = fwd.wen & ~abort & nReset;
    bp_ren    = fwd.ren & ~abort & nReset;
    bp_addr   = fwd.addr;
    bp_wdata  = fwd.wdata;
    bp_strobe = fwd.strobe;
    for (int i = 0; i < NumReq; i++) begin
      req_rdata[i] = '0;
      req_error[i] = 1'b0;
      req_stall[i] = active[i];
      if (!nReset) begin
        req_stall[i] = 1'b1;
      end else if (gnt_vld && gnt_idx == PW'(i)) begin
        if (abort) begin
          req_error[i] = 1'b1;
          req_stall[i] = 1'b0;
        end else begin
          req_rdata[i] = bp_rdata;
          req_error[i] = bp_error;
          req_stall[i] = bp_stall;
        end
      end
    end
  end
endmodule
